// File: rtl/word32_8bits_arbiter.sv
// Round-robin arbiter that feeds one 32->8 serializer from N_LANES word sources.
// A granted word is held on ser_data for exactly four byte beats. Words from
// different lanes follow each other with no valid gap while requests persist.
module word32_8bits_arbiter #(
    parameter int N_LANES = 4,
    parameter int LANE_W  = 2
) (
    input  logic                   clk_4f,
    input  logic                   reset_L,
    input  logic                   en,
    input  logic [N_LANES-1:0]     req_valid,
    input  logic [32*N_LANES-1:0]  req_data,
    output logic [N_LANES-1:0]     req_ack,
    output logic                   ser_valid,
    output logic [31:0]            ser_data,
    output logic [LANE_W-1:0]      ser_lane,
    output logic                   busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t              r_state;
    logic [1:0]          r_beat;
    logic [LANE_W-1:0]   r_rr_ptr;
    logic [N_LANES-1:0]  r_ack;
    logic                r_ser_valid;
    logic [31:0]         r_ser_data;
    logic [LANE_W-1:0]   r_ser_lane;
    logic                r_busy;

    state_t              w_state_nx;
    logic [1:0]          w_beat_nx;
    logic [LANE_W-1:0]   w_rr_nx;
    logic [N_LANES-1:0]  w_ack_nx;
    logic                w_valid_nx;
    logic [31:0]         w_data_nx;
    logic [LANE_W-1:0]   w_lane_nx;
    logic                w_busy_nx;

    logic [LANE_W:0]     w_pick;
    logic                w_found;
    logic [LANE_W-1:0]   w_g;
    logic [31:0]         w_word;
    logic                w_take;

    // First requesting lane at or after ptr, wrapping modulo N_LANES.
    // Result is {found, lane}.
    function automatic logic [LANE_W:0] f_pick(input logic [N_LANES-1:0] vld,
                                               input logic [LANE_W-1:0]  ptr);
        logic              found;
        logic [LANE_W-1:0] g;
        int                best;
        int                d;
        found = 1'b0;
        g     = '0;
        best  = N_LANES;
        for (int j = 0; j < N_LANES; j++) begin
            d = j - int'(ptr);
            if (d < 0) d = d + N_LANES;
            if (vld[j] && d < best) begin
                best  = d;
                found = 1'b1;
                g     = LANE_W'(j);
            end
        end
        return {found, g};
    endfunction

    // Pointer increment that wraps N_LANES-1 back to lane 0.
    function automatic logic [LANE_W-1:0] f_next(input logic [LANE_W-1:0] g);
        if (int'(g) == N_LANES - 1) return '0;
        return g + LANE_W'(1);
    endfunction

    // Grant candidate and its word, selected from the round-robin pointer.
    always_comb begin
        w_pick  = f_pick(req_valid, r_rr_ptr);
        w_found = w_pick[LANE_W];
        w_g     = w_pick[LANE_W-1:0];
        w_word  = '0;
        for (int j = 0; j < N_LANES; j++) begin
            if (LANE_W'(j) == w_g) w_word = req_data[32*j +: 32];
        end
        // A new grant may start from IDLE or at the last beat of a word.
        w_take = en && w_found && (r_state == S_IDLE || r_beat == 2'd3);
    end

    // Next-state and next-output logic for the IDLE/SEND scheduler.
    always_comb begin
        w_state_nx = r_state;
        w_beat_nx  = r_beat;
        w_rr_nx    = r_rr_ptr;
        w_ack_nx   = '0;
        w_valid_nx = r_ser_valid;
        w_data_nx  = r_ser_data;
        w_lane_nx  = r_ser_lane;
        w_busy_nx  = r_busy;
        case (r_state)
            S_IDLE: begin
                w_valid_nx = 1'b0;
                w_busy_nx  = 1'b0;
                w_beat_nx  = 2'd0;
            end
            S_SEND: begin
                w_beat_nx = r_beat + 2'd1;
                if (r_beat == 2'd3 && !w_take) begin
                    w_valid_nx = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_take) begin
            w_state_nx = S_SEND;
            w_beat_nx  = 2'd0;
            w_data_nx  = w_word;
            w_lane_nx  = w_g;
            w_ack_nx   = N_LANES'(1) << w_g;
            w_valid_nx = 1'b1;
            w_busy_nx  = 1'b1;
            w_rr_nx    = f_next(w_g);
        end
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= S_IDLE;
            r_beat      <= 2'd0;
            r_rr_ptr    <= '0;
            r_ack       <= '0;
            r_ser_valid <= 1'b0;
            r_ser_data  <= '0;
            r_ser_lane  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_beat      <= w_beat_nx;
            r_rr_ptr    <= w_rr_nx;
            r_ack       <= w_ack_nx;
            r_ser_valid <= w_valid_nx;
            r_ser_data  <= w_data_nx;
            r_ser_lane  <= w_lane_nx;
            r_busy      <= w_busy_nx;
        end
    end

    assign req_ack   = r_ack;
    assign ser_valid = r_ser_valid;
    assign ser_data  = r_ser_data;
    assign ser_lane  = r_ser_lane;
    assign busy      = r_busy;

endmodule

// File: tb/tb_word32_8bits_arbiter.sv
// Testbench for word32_8bits_arbiter: directed lane requests, expected grants
// queued by the stimulus, checked by an independent output monitor.
module tb_word32_8bits_arbiter;

    localparam int N_LANES = 4;
    localparam int LANE_W  = 2;

    logic                  clk_4f;
    logic                  reset_L;
    logic                  en;
    logic [N_LANES-1:0]    req_valid;
    logic [32*N_LANES-1:0] req_data;
    logic [N_LANES-1:0]    req_ack;
    logic                  ser_valid;
    logic [31:0]           ser_data;
    logic [LANE_W-1:0]     ser_lane;
    logic                  busy;

    word32_8bits_arbiter #(.N_LANES(N_LANES), .LANE_W(LANE_W)) dut (
        .clk_4f    (clk_4f),
        .reset_L   (reset_L),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_lane  (ser_lane),
        .busy      (busy)
    );

    initial clk_4f = 1'b0;
    always #5 clk_4f = ~clk_4f;

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic [31:0]       word;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          lane_rem [N_LANES];
    logic [31:0] lane_word[N_LANES];

    // monitor state
    logic        in_word = 1'b0;
    int          mon_beat = 0;
    exp_t        cur;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic set_lane(input logic [1:0] l, input int n, input logic [31:0] w);
        lane_rem[l]  = n;
        lane_word[l] = w;
    endtask

    task automatic push(input logic [1:0] l, input logic [31:0] w);
        exp_t e;
        e.lane = l;
        e.word = w;
        exp_q.push_back(e);
    endtask

    task automatic drive();
        for (int i = 0; i < N_LANES; i++) begin
            req_valid[2'(i)]      = (lane_rem[2'(i)] > 0);
            req_data[32*i +: 32]  = lane_word[2'(i)];
        end
    endtask

    // Advance to the next falling edge; a lane whose word was acked moves to
    // its next word (or drops its request when it has none left).
    task automatic step();
        @(negedge clk_4f);
        for (int i = 0; i < N_LANES; i++) begin
            if (req_ack[2'(i)] && lane_rem[2'(i)] > 0) begin
                lane_rem[2'(i)]  = lane_rem[2'(i)] - 1;
                lane_word[2'(i)] = lane_word[2'(i)] + 32'h01010101;
            end
        end
        drive();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < N_LANES; i++) set_lane(2'(i), 0, 32'h0);
        drive();
    endtask

    // Output monitor: every ack starts a word that must match the queue head,
    // then exactly four beats of stable data, one byte per beat.
    initial begin
        forever begin
            @(negedge clk_4f);
            if (!reset_L) begin
                in_word  = 1'b0;
                mon_beat = 0;
            end else if (|req_ack) begin
                if (in_word) chk("word_len_b2b", 32'(mon_beat), 32'd4);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_ack: got ack %b lane %0d, required no grant at %0t",
                             req_ack, ser_lane, $time);
                    in_word = 1'b0;
                end else begin
                    cur = exp_q.pop_front();
                    chk("grant_lane", 32'(ser_lane), 32'(cur.lane));
                    chk("grant_data", ser_data, cur.word);
                    chk("ack_onehot", 32'(req_ack), 32'(4'b0001 << cur.lane));
                    chk("valid_on_ack", 32'(ser_valid), 32'd1);
                    chk("busy_on_ack", 32'(busy), 32'd1);
                    chk("byte0", 32'(ser_data[31:24]), 32'(cur.word[31:24]));
                    in_word  = 1'b1;
                    mon_beat = 1;
                end
            end else if (ser_valid) begin
                if (!in_word) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL valid_without_grant: got ser_valid 1, required 0 at %0t", $time);
                end else if (mon_beat >= 4) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL word_too_long: got beat %0d, required at most 4 at %0t",
                             mon_beat + 1, $time);
                    in_word = 1'b0;
                end else begin
                    chk("data_stable", ser_data, cur.word);
                    chk("lane_stable", 32'(ser_lane), 32'(cur.lane));
                    chk("ser_byte", 32'(8'(ser_data >> (8*(3-mon_beat)))),
                        32'(8'(cur.word >> (8*(3-mon_beat)))));
                    mon_beat++;
                end
            end else if (in_word) begin
                chk("word_len", 32'(mon_beat), 32'd4);
                chk("busy_after_word", 32'(busy), 32'd0);
                in_word = 1'b0;
            end
        end
    end

    int nv;

    // Directed stimulus; each grant's expected lane/word is queued up front.
    initial begin
        reset_L = 1'b1;
        en      = 1'b0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N_LANES; i++) set_lane(2'(i), 0, 32'h0);
        drive();
        #1 reset_L = 1'b0;
        #1;
        chk("rst_valid", 32'(ser_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_data", ser_data, 32'd0);
        chk("rst_lane", 32'(ser_lane), 32'd0);
        steps(2);
        #2 reset_L = 1'b1;
        en = 1'b1;

        // all four lanes, two words each: rotation 0,1,2,3,0,1,2,3, no gap
        for (int i = 0; i < N_LANES; i++) set_lane(2'(i), 2, 32'h10203040 + 32'(i));
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N_LANES; i++)
                push(2'(i), 32'h10203040 + 32'(i) + 32'(k) * 32'h01010101);
        drive();
        step();
        nv = 0;
        for (int c = 0; c < 32; c++) begin
            if (ser_valid) nv++;
            step();
        end
        chk("t2_valid_cycles", 32'(nv), 32'd32);
        chk("t2_idle_valid", 32'(ser_valid), 32'd0);
        chk("t2_idle_busy", 32'(busy), 32'd0);

        // single word on lane 0
        set_lane(2'd0, 1, 32'hA1B2C3D4);
        push(2'd0, 32'hA1B2C3D4);
        drive();
        step();
        chk("t1_latency", 32'(ser_valid), 32'd1);
        steps(3);
        chk("t1_beat4_valid", 32'(ser_valid), 32'd1);
        step();
        chk("t1_end_valid", 32'(ser_valid), 32'd0);
        chk("t1_end_busy", 32'(busy), 32'd0);
        steps(2);

        // move the pointer to 2 with one lane-1 word
        set_lane(2'd1, 1, 32'h5EED0001);
        push(2'd1, 32'h5EED0001);
        drive();
        steps(6);

        // lanes 1 and 3 with pointer at 2: lane 3 first, then lane 1
        set_lane(2'd1, 1, 32'h13131313);
        set_lane(2'd3, 1, 32'h33333333);
        push(2'd3, 32'h33333333);
        push(2'd1, 32'h13131313);
        drive();
        steps(10);
        chk("t3_idle_valid", 32'(ser_valid), 32'd0);

        // en dropped at beat 1: word completes, no further grant; pointer now 2
        for (int i = 0; i < N_LANES; i++) set_lane(2'(i), 3, 32'h40404040 + 32'(i));
        push(2'd2, 32'h40404042);
        drive();
        steps(2);
        en = 1'b0;
        steps(2);
        chk("t4_beat4_valid", 32'(ser_valid), 32'd1);
        step();
        chk("t4_end_valid", 32'(ser_valid), 32'd0);
        steps(3);
        chk("t4_idle_busy", 32'(busy), 32'd0);
        chk("t4_idle_ack", 32'(req_ack), 32'd0);
        push(2'd3, lane_word[3]);
        en = 1'b1;
        step();
        en = 1'b0;
        steps(5);
        chk("t4_resume_idle", 32'(ser_valid), 32'd0);
        clear_lanes();
        en = 1'b1;
        steps(2);

        // lane 2 pulses for one cycle mid-word: ignored; pointer stays at 1
        set_lane(2'd0, 1, 32'h60606060);
        push(2'd0, 32'h60606060);
        drive();
        steps(2);
        set_lane(2'd2, 1, 32'h22222222);
        drive();
        step();
        set_lane(2'd2, 0, 32'h0);
        drive();
        steps(2);
        chk("t6_idle_valid", 32'(ser_valid), 32'd0);
        set_lane(2'd0, 1, 32'h0A0A0A0A);
        set_lane(2'd1, 1, 32'h1B1B1B1B);
        push(2'd1, 32'h1B1B1B1B);
        push(2'd0, 32'h0A0A0A0A);
        drive();
        steps(10);
        chk("t6_idle_after", 32'(ser_valid), 32'd0);

        // asynchronous reset at beat 2, then lane 0 is granted first
        for (int i = 0; i < N_LANES; i++) set_lane(2'(i), 1, 32'h70707070 + 32'(i));
        push(2'd1, 32'h70707071);
        drive();
        steps(3);
        #2 reset_L = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(ser_valid), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ack", 32'(req_ack), 32'd0);
        chk("t5_rst_data", ser_data, 32'd0);
        chk("t5_rst_lane", 32'(ser_lane), 32'd0);
        for (int i = 0; i < N_LANES; i++) set_lane(2'(i), 1, 32'h50000000 + 32'(i));
        push(2'd0, 32'h50000000);
        drive();
        steps(2);
        #2 reset_L = 1'b1;
        step();
        en = 1'b0;
        steps(5);
        chk("t5_idle_valid", 32'(ser_valid), 32'd0);
        clear_lanes();
        steps(2);

        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
